unary_op_block: RTL and testbench

Parametrised execution block for the Nock unary opcodes 3 (cell test) and 4 (increment). It generalises the single-mode cell-test block, and it returns a result or an error code to traversal instead of halting. It sits behind the memory mux and is selected by the traversal mux-controller code. It classifies the operand, issuing one memory read when the operand tel points to a word. It then writes the result word back to the node address and raises finished.

---
 rtl/unary_op_block_pkg.sv | 47 ++++
 rtl/unary_op_block_if.sv | 24 ++
 rtl/unary_op_block_noun_classify.sv | 32 +++
 rtl/unary_op_block.sv | 203 ++++++++++++++++++++
 tb/tb_unary_op_block.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_op_block_pkg.sv
// Shared definitions for the unary (cell-test / increment) execution block:
// noun tags, memory function codes, mux codes, error codes and FSM states.
package unary_op_block_pkg;

   localparam logic ATOM = 1'b0;
   localparam logic CELL = 1'b1;

   typedef enum logic [1:0] {
      MEM_NONE     = 2'd0,
      GET_CONTENTS = 2'd1,
      SET_CONTENTS = 2'd2
   } mem_func_e;

   typedef enum logic [2:0] {
      MUX_NONE = 3'd0,
      MUX_CELL = 3'd3,
      MUX_INCR = 3'd4
   } mux_code_e;

   typedef enum logic [7:0] {
      ERR_OK        = 8'h00,
      ERR_INCR_CELL = 8'h01,
      ERR_OVERFLOW  = 8'h02,
      ERR_TIMEOUT   = 8'h03
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INIT       = 3'd1,
      ST_READ_TEL   = 3'd2,
      ST_WRITE      = 3'd3,
      ST_WRITE_WAIT = 3'd4,
      ST_DONE       = 3'd5
   } state_e;

   typedef enum logic {
      MODE_CELL = 1'b0,
      MODE_INCR = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      NOUN_DIRECT = 2'd0,
      NOUN_MARKER = 2'd1,
      NOUN_CELL   = 2'd2
   } noun_kind_e;

endpackage

// File: rtl/unary_op_block_if.sv
// Memory-mux side bus of the unary block: request strobe, addresses,
// function code, write word, and the read completion pulse/data.
interface unary_op_block_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 64
) ();
   logic              mem_execute;
   logic [ADDR_W-1:0] address1;
   logic [ADDR_W-1:0] address2;
   logic [1:0]        mem_func;
   logic [DATA_W-1:0] write_data;
   logic              mem_ready;
   logic [DATA_W-1:0] read_data1;

   modport master (
      output mem_execute, address1, address2, mem_func, write_data,
      input  mem_ready, read_data1
   );

   modport slave (
      input  mem_execute, address1, address2, mem_func, write_data,
      output mem_ready, read_data1
   );
endinterface

// File: rtl/unary_op_block_noun_classify.sv
// Combinational classification of a noun word by its tel:
// cell pointer, indirect-atom marker (both tags atom, tel NIL) or direct atom.
module unary_op_block_noun_classify
   import unary_op_block_pkg::*;
#(
   parameter  int HALF_W = 28,
   localparam int DATA_W = 2*HALF_W + 8
) (
   input  logic [DATA_W-1:0] word,
   output noun_kind_e        kind
);
   localparam logic [HALF_W-1:0] NIL = '1;

   logic              hed_tag;
   logic              tel_tag;
   logic [HALF_W-1:0] tel;
   logic              unused_bits;

   assign hed_tag     = word[2*HALF_W+1];
   assign tel_tag     = word[2*HALF_W];
   assign tel         = word[HALF_W-1:0];
   assign unused_bits = ^{word[DATA_W-1:2*HALF_W+2], word[2*HALF_W-1:HALF_W]};

   always_comb begin
      kind = NOUN_DIRECT;
      if (tel_tag == CELL) begin
         kind = NOUN_CELL;
      end else if ((hed_tag == ATOM) && (tel == NIL)) begin
         kind = NOUN_MARKER;
      end
   end
endmodule

// File: rtl/unary_op_block.sv
// Execution block for Nock opcodes 3 (cell test) and 4 (increment).
// Optional mem_ready watchdog enabled by defining UNARY_MEM_TIMEOUT_EN.
//
// state         | meaning
// ST_IDLE       | not selected by the traversal mux
// ST_INIT       | classify operand; direct atom computes, cell issues GET
// ST_READ_TEL   | waiting for the operand read
// ST_WRITE      | one-cycle SET strobe of the result word
// ST_WRITE_WAIT | waiting for the write completion
// ST_DONE       | finished high, no memory activity
module unary_op_block
   import unary_op_block_pkg::*;
#(
   parameter  int        HALF_W         = 28,
   parameter  int        ADDR_W         = 28,
   parameter  logic [2:0] MUX_CELL_CODE = MUX_CELL,
   parameter  logic [2:0] MUX_INCR_CODE = MUX_INCR,
   parameter  int        TIMEOUT_CYCLES = 256,
   localparam int        DATA_W         = 2*HALF_W + 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           block_start,
   input  logic [ADDR_W-1:0]    cell_address,
   input  logic [DATA_W-1:0]    cell_data,
   unary_op_block_if.master     mem,
   output logic [7:0]           error,
   output logic                 finished
);
   localparam logic [HALF_W-1:0] NIL        = '1;
   localparam logic [HALF_W-1:0] MAX_DIRECT = {1'b0, {(HALF_W-1){1'b1}}};
   localparam int                SPARE_W    = DATA_W - 2*HALF_W - 2;

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [2:0]        block_start_q;
   logic [HALF_W-1:0] result_q, result_d;
   logic [7:0]        error_q, error_d;
   logic              finished_q, finished_d;

   logic              mem_execute_c;
   mem_func_e         mem_func_c;
   logic [ADDR_W-1:0] address1_c;
   logic [DATA_W-1:0] write_data_c;

   logic              sel;
   logic              start;
   noun_kind_e        op_kind;
   noun_kind_e        rd_kind;
   logic [HALF_W-1:0] op_tel;

`ifdef UNARY_MEM_TIMEOUT_EN
   localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   unary_op_block_noun_classify #(.HALF_W(HALF_W)) u_classify_op (
      .word (cell_data),
      .kind (op_kind)
   );

   unary_op_block_noun_classify #(.HALF_W(HALF_W)) u_classify_rd (
      .word (mem.read_data1),
      .kind (rd_kind)
   );

   assign op_tel = cell_data[HALF_W-1:0];
   assign sel    = (block_start == MUX_CELL_CODE) || (block_start == MUX_INCR_CODE);
   // Switching directly between the two mode codes is also a fresh start.
   assign start  = sel && (block_start != block_start_q);

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      result_d      = result_q;
      error_d       = error_q;
      finished_d    = finished_q;
      mem_execute_c = 1'b0;
      mem_func_c    = MEM_NONE;
      address1_c    = '0;
      write_data_c  = '0;
`ifdef UNARY_MEM_TIMEOUT_EN
      tmo_d         = '0;
`endif
      if (!sel) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d    = ST_INIT;
         mode_d     = (block_start == MUX_INCR_CODE) ? MODE_INCR : MODE_CELL;
         error_d    = ERR_OK;
         finished_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (op_kind != NOUN_CELL) begin
                  if (mode_q == MODE_CELL) begin
                     result_d = HALF_W'(1);
                     state_d  = ST_WRITE;
                  end else if (op_tel >= MAX_DIRECT) begin
                     // Anything past the direct range would need an indirect atom.
                     error_d    = ERR_OVERFLOW;
                     finished_d = 1'b1;
                     state_d    = ST_DONE;
                  end else begin
                     result_d = op_tel + HALF_W'(1);
                     state_d  = ST_WRITE;
                  end
               end else begin
                  mem_execute_c = 1'b1;
                  mem_func_c    = GET_CONTENTS;
                  address1_c    = op_tel[ADDR_W-1:0];
                  state_d       = ST_READ_TEL;
               end
            end
            ST_READ_TEL: begin
               if (mem.mem_ready) begin
                  if (mode_q == MODE_CELL) begin
                     result_d = (rd_kind == NOUN_MARKER) ? HALF_W'(1) : '0;
                     state_d  = ST_WRITE;
                  end else begin
                     error_d    = (rd_kind == NOUN_MARKER) ? ERR_OVERFLOW : ERR_INCR_CELL;
                     finished_d = 1'b1;
                     state_d    = ST_DONE;
                  end
               end
`ifdef UNARY_MEM_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  error_d    = ERR_TIMEOUT;
                  finished_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
`endif
            end
            ST_WRITE: begin
               mem_execute_c = 1'b1;
               mem_func_c    = SET_CONTENTS;
               address1_c    = cell_address;
               write_data_c  = {{SPARE_W{1'b0}}, ATOM, ATOM, result_q, NIL};
               state_d       = ST_WRITE_WAIT;
            end
            ST_WRITE_WAIT: begin
               if (mem.mem_ready) begin
                  finished_d = 1'b1;
                  state_d    = ST_DONE;
               end
`ifdef UNARY_MEM_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  error_d    = ERR_TIMEOUT;
                  finished_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_CELL;
         block_start_q <= '0;
         result_q      <= '0;
         error_q       <= '0;
         finished_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         block_start_q <= block_start;
         result_q      <= result_d;
         error_q       <= error_d;
         finished_q    <= finished_d;
      end
   end

`ifdef UNARY_MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign mem.mem_execute = mem_execute_c;
   assign mem.mem_func    = mem_func_c;
   assign mem.address1    = address1_c;
   assign mem.address2    = '0;
   assign mem.write_data  = write_data_c;
   assign error           = error_q;
   assign finished        = finished_q;

endmodule

// File: tb/tb_unary_op_block.sv
// Directed bench for unary_op_block: behavioural memory, spec-level model of
// expected memory transactions and error codes, per-cycle bus compare.
module tb_unary_op_block;
   localparam logic [27:0] NIL   = 28'hFFF_FFFF;
   localparam logic [27:0] MAXD  = 28'h7FF_FFFF;
   localparam logic [1:0]  GET_F = 2'd1;
   localparam logic [1:0]  SET_F = 2'd2;

   typedef struct {
      logic [1:0]  func;
      logic [27:0] addr;
      logic [63:0] data;
   } txn_t;

   logic        clk;
   logic        rst;
   logic [2:0]  block_start;
   logic [27:0] cell_address;
   logic [63:0] cell_data;
   logic [7:0]  error;
   logic        finished;

   unary_op_block_if #(.ADDR_W(28), .DATA_W(64)) mem_if ();

   unary_op_block #(
      .HALF_W(28), .ADDR_W(28), .MUX_CELL_CODE(3'd3), .MUX_INCR_CODE(3'd4), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .block_start(block_start), .cell_address(cell_address),
      .cell_data(cell_data), .mem(mem_if.master), .error(error), .finished(finished)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          txn_cnt = 0;
   int          resp_cnt = 0;
   int          mem_lat = 1;
   bit          withhold = 0;
   logic [63:0] rd_word = '0;
   logic [63:0] last_set_data = '0;
   logic [27:0] last_set_addr = '0;
   txn_t        exp_q[$];
   txn_t        got_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic ht, input logic tt, input logic [27:0] h, input logic [27:0] t);
      return {6'b0, ht, tt, h, t};
   endfunction

   // Spec-level expectation: memory transactions to appear and final error code.
   task automatic model(input bit inc, input logic [63:0] cd, input logic [63:0] rd,
                        input logic [27:0] ca, output logic [7:0] err);
      logic [27:0] tel;
      logic [27:0] res;
      bit          has_res;
      bit          marker;
      tel = cd[27:0]; err = 8'h00; has_res = 0; res = '0;
      if (cd[56] == 1'b0) begin
         if (!inc) begin res = 28'd1; has_res = 1; end
         else if (tel == MAXD) err = 8'h02;
         else begin res = tel + 28'd1; has_res = 1; end
      end else begin
         exp_q.push_back(txn_t'{GET_F, tel, 64'h0});
         marker = (rd[57:56] == 2'b00) && (rd[27:0] == NIL);
         if (!inc) begin res = marker ? 28'd1 : 28'd0; has_res = 1; end
         else err = marker ? 8'h02 : 8'h01;
      end
      if (has_res) exp_q.push_back(txn_t'{SET_F, ca, {6'b0, 2'b00, res, NIL}});
   endtask

   // Memory: answers each strobe with a one-cycle mem_ready after mem_lat cycles.
   always @(negedge clk) begin
      mem_if.mem_ready = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt = resp_cnt - 1;
         if (resp_cnt == 0) begin
            mem_if.mem_ready  = 1'b1;
            mem_if.read_data1 = rd_word;
         end
      end
      if (rst && mem_if.mem_execute) begin
         if (mem_if.mem_func == SET_F) begin
            last_set_data = mem_if.write_data;
            last_set_addr = mem_if.address1;
         end
         if (!withhold) resp_cnt = mem_lat;
      end
   end

   // Per-cycle bus compare against the expected transaction queue.
   always @(negedge clk) begin
      if (rst) begin
         chk("address2_tied", 64'(mem_if.address2), 64'd0);
         if (mem_if.mem_execute) begin
            txn_cnt++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_txn: func %0d addr %h data %h expected none",
                        mem_if.mem_func, mem_if.address1, mem_if.write_data);
            end else begin
               got_t = exp_q.pop_front();
               chk("txn_func", 64'(mem_if.mem_func), 64'(got_t.func));
               chk("txn_addr", 64'(mem_if.address1), 64'(got_t.addr));
               if (got_t.func == SET_F) chk("txn_wdata", mem_if.write_data, got_t.data);
            end
         end else begin
            chk("idle_func", 64'(mem_if.mem_func), 64'd0);
         end
      end
   end

   task automatic do_op(input logic [2:0] code, input logic [63:0] cd, input logic [27:0] ca,
                        input logic [63:0] rd, input bit desel, output int lat);
      logic [7:0] exp_err;
      int         start_cyc;
      if (desel) begin @(posedge clk); #1; block_start = 3'd0; end
      model(code == 3'd4, cd, rd, ca, exp_err);
      @(posedge clk); #1;
      rd_word = rd; cell_data = cd; cell_address = ca; block_start = code; start_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      chk("start_clears_finished", 64'(finished), 64'd0);
      chk("start_clears_error", 64'(error), 64'd0);
      for (int i = 0; i < 60 && !finished; i++) @(negedge clk);
      lat = cyc - start_cyc;
      chk("finished_reached", 64'(finished), 64'd1);
      chk("op_error", 64'(error), 64'(exp_err));
      chk("no_pending_txn", 64'(exp_q.size()), 64'd0);
   endtask

   int          lat;
   int          txn_before;
   logic [7:0]  e;
   logic [63:0] cd;
   logic [63:0] rd;

   initial begin
      rst = 1'b0; block_start = 3'd0; cell_address = '0; cell_data = '0;
      mem_if.mem_ready = 1'b0; mem_if.read_data1 = '0;
      repeat (2) @(posedge clk); #1;
      chk("rst_finished", 64'(finished), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_exec", 64'(mem_if.mem_execute), 64'd0);
      chk("rst_func", 64'(mem_if.mem_func), 64'd0);
      chk("rst_addr1", 64'(mem_if.address1), 64'd0);
      chk("rst_wdata", mem_if.write_data, 64'd0);
      rst = 1'b1;

      do_op(3'd3, mk(0, 0, 28'h0, 28'd5), 28'h10, 64'h0, 1, lat);
      chk("cell_direct_latency", 64'(lat), 64'd4);
      chk("cell_direct_wdata", last_set_data, 64'h0000_0000_1FFF_FFFF);
      chk("cell_direct_waddr", 64'(last_set_addr), 64'h10);
      #1 resp_cnt = 1;
      repeat (3) @(negedge clk);
      chk("done_ignores_ready", 64'(finished), 64'd1);

      do_op(3'd3, mk(0, 1, 28'h0, 28'h20), 28'h11, mk(1, 0, 28'h5, 28'h6), 1, lat);
      chk("cell_ptr_wdata", last_set_data, 64'h0000_0000_0FFF_FFFF);
      chk("cell_ptr_waddr", 64'(last_set_addr), 64'h11);
      do_op(3'd3, mk(0, 1, 28'h0, 28'h21), 28'h12, mk(0, 0, 28'h123, NIL), 1, lat);
      chk("cell_marker_wdata", last_set_data, 64'h0000_0000_1FFF_FFFF);

      do_op(3'd4, mk(0, 0, 28'h0, 28'd41), 28'h13, 64'h0, 1, lat);
      chk("incr_41_wdata", last_set_data, 64'h0000_0002_AFFF_FFFF);
      do_op(3'd4, mk(0, 0, 28'h0, MAXD), 28'h14, 64'h0, 1, lat);
      chk("incr_max_err", 64'(error), 64'h02);
      do_op(3'd4, mk(0, 1, 28'h0, 28'h22), 28'h15, mk(1, 1, 28'h1, 28'h2), 1, lat);
      chk("incr_cell_err", 64'(error), 64'h01);
      @(posedge clk); #1 block_start = 3'd0;
      repeat (2) @(negedge clk);
      chk("deselect_holds_error", 64'(error), 64'h01);
      chk("deselect_holds_finished", 64'(finished), 64'd1);

      mem_lat = 3;
      do_op(3'd4, mk(0, 1, 28'h0, 28'h23), 28'h15, mk(0, 0, 28'h0, NIL), 1, lat);
      chk("incr_marker_err", 64'(error), 64'h02);
      mem_lat = 1;
      do_op(3'd4, mk(0, 0, 28'h0, 28'd0), 28'h16, 64'h0, 1, lat);
      chk("incr_zero_wdata", last_set_data, 64'h0000_0000_1FFF_FFFF);
      do_op(3'd4, mk(0, 0, 28'h0, MAXD - 28'd1), 28'h16, 64'h0, 1, lat);
      chk("incr_max_minus1_wdata", last_set_data, 64'h007F_FFFF_FFFF_FFFF);
      do_op(3'd3, mk(0, 0, 28'h0, 28'd9), 28'h1A, 64'h0, 0, lat);
      chk("mode_switch_waddr", 64'(last_set_addr), 64'h1A);
      chk("mode_switch_wdata", last_set_data, 64'h0000_0000_1FFF_FFFF);

      // Deselect then reselect while a read is outstanding.
      @(posedge clk); #1 block_start = 3'd0; withhold = 1;
      exp_q.push_back(txn_t'{GET_F, 28'h40, 64'h0});
      @(posedge clk); #1 cell_data = mk(0, 1, 28'h0, 28'h40); block_start = 3'd4; txn_before = txn_cnt;
      repeat (4) @(negedge clk);
      chk("abort_get_issued", 64'(txn_cnt - txn_before), 64'd1);
      @(posedge clk); #1 block_start = 3'd0;
      @(negedge clk);
      chk("deselect_no_strobe", 64'(mem_if.mem_execute), 64'd0);
      chk("deselect_not_finished", 64'(finished), 64'd0);
      withhold = 0;
      do_op(3'd4, mk(0, 1, 28'h0, 28'h40), 28'h17, mk(1, 0, 28'h3, 28'h4), 1, lat);
      chk("restart_err", 64'(error), 64'h01);

      // Reset while waiting for the write completion.
      withhold = 1;
      model(1, mk(0, 0, 28'h0, 28'd41), 64'h0, 28'h30, e);
      @(posedge clk); #1 block_start = 3'd0;
      @(posedge clk); #1 cell_data = mk(0, 0, 28'h0, 28'd41); cell_address = 28'h30; block_start = 3'd4;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst = 1'b0; #1;
      chk("rst_ww_exec", 64'(mem_if.mem_execute), 64'd0);
      chk("rst_ww_func", 64'(mem_if.mem_func), 64'd0);
      chk("rst_ww_addr1", 64'(mem_if.address1), 64'd0);
      chk("rst_ww_wdata", mem_if.write_data, 64'd0);
      chk("rst_ww_finished", 64'(finished), 64'd0);
      chk("rst_ww_error", 64'(error), 64'd0);
      chk("rst_ww_write_seen", 64'(exp_q.size()), 64'd0);
      block_start = 3'd0; withhold = 0; resp_cnt = 0;
      @(posedge clk); #1 rst = 1'b1;

      // Read withheld: watchdog (if built) or indefinite wait.
      withhold = 1;
      cd = mk(0, 1, 28'h0, 28'h50);
      rd = mk(0, 0, 28'h1, NIL);
`ifdef UNARY_MEM_TIMEOUT_EN
      exp_q.push_back(txn_t'{GET_F, 28'h50, 64'h0});
`else
      model(0, cd, rd, 28'h18, e);
`endif
      @(posedge clk); #1 cell_data = cd; cell_address = 28'h18; rd_word = rd; block_start = 3'd3;
      repeat (40) @(negedge clk);
`ifdef UNARY_MEM_TIMEOUT_EN
      chk("timeout_finished", 64'(finished), 64'd1);
      chk("timeout_err", 64'(error), 64'h03);
`else
      chk("wait_not_finished", 64'(finished), 64'd0);
      chk("wait_no_error", 64'(error), 64'd0);
`endif
      withhold = 0;
      #1 resp_cnt = 1;
      repeat (6) @(negedge clk);
`ifdef UNARY_MEM_TIMEOUT_EN
      chk("late_ready_err", 64'(error), 64'h03);
      chk("late_ready_finished", 64'(finished), 64'd1);
`else
      chk("late_ready_finished", 64'(finished), 64'd1);
      chk("late_ready_err", 64'(error), 64'd0);
      chk("late_ready_wdata", last_set_data, 64'h0000_0000_1FFF_FFFF);
`endif
      chk("final_no_pending", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
